alu_seq_ctrl: RTL
=================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset_n  input  1  reset, asynchronous, active-low.
REQ-003 op_valid  input  1  requester presents an operation.
REQ-004 op_ready  output  1  controller accepts; high only in IDLE.
REQ-005 opcode  input  4  0 NOP, 1 NOT_A, 2 NOT_B, 3 AND, 4 OR, 5 XOR, 6 XNOR, 7 LSL, 8 LSR, 9 ASR, A ADD, B SUB, C MUL, D-F illegal.
REQ-006 op_a, op_b  input  64 each  operands; shift amount = op_b[1:0].
REQ-007 res_valid  output  1  result available.
REQ-008 res_ready  input  1  requester consumes result.
REQ-009 result  output  64  registered result.
REQ-010 err  output  1  illegal opcode or multiplier timeout; valid with res_valid.
REQ-011 alu_sel  output  4  combinational-datapath select, equals latched opcode.
REQ-012 alu_a, alu_b  output  64 each  latched operands to datapath.
REQ-013 alu_shamt  output  2  latched op_b[1:0].
REQ-014 alu_y  input  64  combinational datapath result.
REQ-015 mul_start, mul_clear  output  1 each  multiplier op_start / op_clear pulses.
REQ-016 mul_multiplier, mul_multiplicand  output  32 each  latched op_a[31:0], op_b[31:0].
REQ-017 mul_done  input  1  multiplier op_done.
REQ-018 mul_result  input  64  signed 64-bit product.

Function
REQ-019 FSM states SHALL be IDLE, EXEC, MUL_START, MUL_WAIT, RESP.
REQ-020 Accept = op_valid & op_ready at an edge; opcode/operands latched; op_a/op_b changes afterwards ignored.
REQ-021 IDLE -> EXEC on accept of opcode 0-B; IDLE -> MUL_START on opcode C; IDLE -> RESP on D-F with result 0, err 1.
REQ-022 EXEC: one cycle; next edge captures alu_y into result, err 0, -> RESP; res_valid high from edge k+1 after accept edge k.
REQ-023 NOP SHALL yield result 0, err 0, via EXEC path.
REQ-024 MUL_START: mul_start = 1 for exactly one cycle, then -> MUL_WAIT.
REQ-025 MUL_WAIT: on edge with mul_done = 1, capture mul_result, err 0, -> RESP, and assert mul_clear for exactly the following cycle.
REQ-026 RESP: res_valid = 1; result and err held stable until res_ready = 1 sampled, then -> IDLE.
REQ-027 op_valid during non-IDLE states SHALL be ignored (no queuing); requester holds it.
REQ-028 mul_start and mul_clear SHALL never be high in the same cycle.
REQ-029 Minimum throughput: one non-MUL op per 3 cycles with res_ready tied high.

Reset
REQ-030 reset_n low SHALL immediately force IDLE, result 0, err 0, res_valid 0, mul_start 0, mul_clear 0, alu_* 0, mul_multiplier/multiplicand 0; op_ready 1 once reset releases.
REQ-031 Reset mid-operation SHALL abandon it with no response; multiplier shares reset_n.

Configuration
REQ-032 Macro ALU_SEQ_MUL_TIMEOUT_EN defined: 6-bit counter cleared on MUL_START, increments each MUL_WAIT cycle; if 48 cycles pass without mul_done, -> RESP with result 0, err 1, mul_clear pulsed one cycle.
REQ-033 Macro undefined: no counter; MUL_WAIT waits indefinitely for mul_done.

Verification
REQ-034 AND, a=FF00FF00FF00FF00, b=0F0F0F0F0F0F0F0F -> alu_sel 3, result 0F000F000F000F00, err 0, res_valid one edge after accept.
REQ-035 LSL, a=1, b=3 -> alu_shamt 3, result 8; ASR, a=8000000000000000, b=2 -> result E000000000000000.
REQ-036 MUL, a[31:0]=FFFFFFFD, b[31:0]=7 -> single-cycle mul_start, result FFFFFFFFFFFFFFEB after mul_done, single-cycle mul_clear, err 0.
REQ-037 res_ready low 5 cycles in RESP -> result/err/res_valid stable, op_ready 0, new op_valid ignored; accept resumes after res_ready.
REQ-038 opcode E -> RESP next edge, result 0, err 1, no mul_start.
REQ-039 mul_done tied 0: with macro -> err 1, result 0 after 48 wait cycles; without -> stays MUL_WAIT; reset_n pulse mid-wait -> IDLE, all outputs 0.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for an external ALU datapath and a multi-cycle multiplier.
// Optional multiplier watchdog: define ALU_SEQ_MUL_TIMEOUT_EN.
module alu_seq_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    // request side
    input  logic        op_valid_i,
    output logic        op_ready_o,
    input  logic [3:0]  opcode_i,
    input  logic [63:0] op_a_i,
    input  logic [63:0] op_b_i,
    // response side
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [63:0] result_o,
    output logic        err_o,
    // combinational datapath
    output logic [3:0]  alu_sel_o,
    output logic [63:0] alu_a_o,
    output logic [63:0] alu_b_o,
    output logic [1:0]  alu_shamt_o,
    input  logic [63:0] alu_y_i,
    // multiplier
    output logic        mul_start_o,
    output logic        mul_clear_o,
    output logic [31:0] mul_multiplier_o,
    output logic [31:0] mul_multiplicand_o,
    input  logic        mul_done_i,
    input  logic [63:0] mul_result_i,
    // debug
    output logic [2:0]  state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid holders keep payload stable until then, ready never
    // depends combinationally on valid.

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EXEC      = 3'd1,
        MUL_START = 3'd2,
        MUL_WAIT  = 3'd3,
        RESP      = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MUL = 4'hC;

    state_t      state_q, state_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic [63:0] result_q, result_d;
    logic        err_q, err_d;
    logic        mul_clear_q, mul_clear_d;
    logic        accept;
    logic        mul_timeout;

    assign accept = op_valid_i & op_ready_o;

`ifdef ALU_SEQ_MUL_TIMEOUT_EN
    logic [5:0] tmo_cnt_q, tmo_cnt_d;

    // The 48th MUL_WAIT cycle without mul_done gives up on the multiplier.
    assign mul_timeout = (state_q == MUL_WAIT) && (tmo_cnt_q == 6'd47);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == MUL_START) begin
            tmo_cnt_d = 6'd0;
        end else if (state_q == MUL_WAIT) begin
            tmo_cnt_d = tmo_cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= 6'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign mul_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (opcode_i == OP_MUL) begin
                        state_d = MUL_START;
                    end else if (opcode_i > OP_MUL) begin
                        state_d = RESP;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC:      state_d = RESP;
            MUL_START: state_d = MUL_WAIT;
            MUL_WAIT: begin
                if (mul_done_i || mul_timeout) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        op_ready_o  = (state_q == IDLE);
        res_valid_o = (state_q == RESP);
        mul_start_o = (state_q == MUL_START);
    end

    // Operand latch and result capture
    always_comb begin
        opcode_d    = opcode_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        err_d       = err_q;
        mul_clear_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    opcode_d = opcode_i;
                    a_d      = op_a_i;
                    b_d      = op_b_i;
                    if (opcode_i > OP_MUL) begin
                        result_d = 64'd0;
                        err_d    = 1'b1;
                    end
                end
            end
            EXEC: begin
                // NOP reports zero whatever the datapath drives on select 0.
                result_d = (opcode_q == OP_NOP) ? 64'd0 : alu_y_i;
                err_d    = 1'b0;
            end
            MUL_WAIT: begin
                if (mul_done_i) begin
                    result_d    = mul_result_i;
                    err_d       = 1'b0;
                    mul_clear_d = 1'b1;
                end else if (mul_timeout) begin
                    result_d    = 64'd0;
                    err_d       = 1'b1;
                    mul_clear_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opcode_q    <= 4'd0;
            a_q         <= 64'd0;
            b_q         <= 64'd0;
            result_q    <= 64'd0;
            err_q       <= 1'b0;
            mul_clear_q <= 1'b0;
        end else begin
            opcode_q    <= opcode_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            err_q       <= err_d;
            mul_clear_q <= mul_clear_d;
        end
    end

    assign result_o           = result_q;
    assign err_o              = err_q;
    assign mul_clear_o        = mul_clear_q;
    assign alu_sel_o          = opcode_q;
    assign alu_a_o            = a_q;
    assign alu_b_o            = b_q;
    assign alu_shamt_o        = b_q[1:0];
    assign mul_multiplier_o   = a_q[31:0];
    assign mul_multiplicand_o = b_q[31:0];
    assign state_o            = state_q;

endmodule
